// File: rtl/adc_conv_scheduler.sv
`timescale 1ns/1ps
// Serial temperature ADC scheduler: round-robin shares one ADC between two
// requesters, runs the serial command/result frame and returns a tagged result.
module adc_conv_scheduler #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DATA_W  = 10
) (
  input  logic              clk,
  input  logic              rstc_n,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              result_valid,
  output logic              result_id,
  output logic [DATA_W-1:0] result_data,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic              adc_din,
  input  logic              adc_dout
);

  localparam int unsigned NBITS  = 5 + DATA_W;
  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned BIT_W  = $clog2(NBITS);
  localparam int unsigned HOLD_W = $clog2(2 * CLK_DIV);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    SETUP = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [DATA_W-1:0]   shreg;
  logic                cur_id;
  logic                rr_ptr;
  logic                pick_c;
  logic                div_end_c;
  logic                next_din_c;

  // Single request wins outright; on a tie the pointer names the winner.
  always_comb begin
    pick_c = rr_ptr;
    if (req == 2'b01) pick_c = 1'b0;
    else if (req == 2'b10) pick_c = 1'b1;
  end

  assign div_end_c = (div_cnt == DIV_W'(CLK_DIV - 1));

  // Command bit for the period after the current one: {START, SGL, ODD, MSBF}.
  always_comb begin
    next_din_c = 1'b0;
    if (bit_cnt == BIT_W'(0)) next_din_c = 1'b1;
    else if (bit_cnt == BIT_W'(1)) next_din_c = cur_id;
    else if (bit_cnt == BIT_W'(2)) next_din_c = 1'b1;
  end

  always_ff @(posedge clk or negedge rstc_n) begin
    if (!rstc_n) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      hold_cnt     <= '0;
      shreg        <= '0;
      cur_id       <= 1'b0;
      rr_ptr       <= 1'b0;
      gnt          <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_id    <= 1'b0;
      result_data  <= '0;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b0;
      adc_din      <= 1'b0;
    end else begin
      gnt          <= '0;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt    <= pick_c ? 2'b10 : 2'b01;
            busy   <= 1'b1;
            cur_id <= pick_c;
            rr_ptr <= ~pick_c;
            state  <= ARB;
          end
        end
        ARB: begin
          adc_cs_n <= 1'b0;
          adc_sclk <= 1'b0;
          adc_din  <= 1'b1;
          div_cnt  <= '0;
          state    <= SETUP;
        end
        SETUP: begin
          if (div_end_c) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            adc_sclk <= 1'b1;
            shreg    <= {shreg[DATA_W-2:0], adc_dout};
            state    <= SHIFT;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        SHIFT: begin
          if (div_end_c) begin
            div_cnt <= '0;
            if (adc_sclk) begin
              adc_sclk <= 1'b0;
              adc_din  <= next_din_c;
            end else if (bit_cnt == BIT_W'(NBITS - 1)) begin
              // Only the last DATA_W samples survive in shreg; the null bit is gone.
              adc_cs_n     <= 1'b1;
              adc_din      <= 1'b0;
              result_valid <= 1'b1;
              result_data  <= shreg;
              result_id    <= cur_id;
              hold_cnt     <= '0;
              state        <= HOLD;
            end else begin
              bit_cnt  <= bit_cnt + BIT_W'(1);
              adc_sclk <= 1'b1;
              shreg    <= {shreg[DATA_W-2:0], adc_dout};
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_W'(2 * CLK_DIV - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_conv_scheduler.sv
`timescale 1ns/1ps
// Bench for adc_conv_scheduler: directed requests, behavioural ADC models and
// a queue-based scoreboard checking grants, frames and results.
module tb_adc_conv_scheduler;

  localparam int unsigned DW  = 10;
  localparam int unsigned NB  = 5 + DW;
  localparam int unsigned DW6 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstc_n = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [1:0]    gnt;
  logic          busy, result_valid, result_id;
  logic [DW-1:0] result_data;
  logic          adc_cs_n, adc_sclk, adc_din;
  logic          adc_dout = 1'b0;

  logic [1:0]     req6 = 2'b00;
  logic [1:0]     gnt6;
  logic           busy6, result_valid6, result_id6;
  logic [DW6-1:0] result_data6;
  logic           adc_cs_n6, adc_sclk6, adc_din6;
  logic           adc_dout6 = 1'b0;

  adc_conv_scheduler #(.CLK_DIV(4), .DATA_W(DW)) dut (
    .clk(clk), .rstc_n(rstc_n), .req(req), .gnt(gnt), .busy(busy),
    .result_valid(result_valid), .result_id(result_id), .result_data(result_data),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout)
  );

  adc_conv_scheduler #(.CLK_DIV(2), .DATA_W(DW6)) dut6 (
    .clk(clk), .rstc_n(rstc_n), .req(req6), .gnt(gnt6), .busy(busy6),
    .result_valid(result_valid6), .result_id(result_id6), .result_data(result_data6),
    .adc_cs_n(adc_cs_n6), .adc_sclk(adc_sclk6), .adc_din(adc_din6), .adc_dout(adc_dout6)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard queues filled by the stimulus
  logic [1:0]     gnt_q[$];
  logic [DW:0]    res_q[$];
  logic           frame_q[$];
  logic [DW6-1:0] res6_q[$];

  // ADC model for the main instance: per-channel result words
  logic [DW-1:0] word [2];
  logic          null_bit = 1'b0;
  int            rise_cnt = 0;
  int            fall_cnt = 0;
  logic [NB-1:0] din_bits = '0;
  logic          cs_prev = 1'b1;
  logic          sclk_prev = 1'b0;

  always @(posedge clk) begin
    logic exp_id;
    #1;
    if (cs_prev && !adc_cs_n) begin
      rise_cnt = 0;
      fall_cnt = 0;
      adc_dout = 1'b0;
    end
    if (!sclk_prev && adc_sclk) begin
      if (rise_cnt < int'(NB)) din_bits[rise_cnt] = adc_din;
      rise_cnt++;
    end
    if (sclk_prev && !adc_sclk && !adc_cs_n) begin
      fall_cnt++;
      if (fall_cnt == 4) adc_dout = null_bit;
      else if (fall_cnt >= 5 && fall_cnt < int'(NB))
        adc_dout = word[din_bits[2]][int'(DW) - 1 - (fall_cnt - 5)];
      else adc_dout = 1'b0;
    end
    if (!cs_prev && adc_cs_n && rstc_n) begin
      if (frame_q.size() == 0) begin
        check("frame_unexpected", 32'd1, 32'd0);
      end else begin
        exp_id = frame_q.pop_front();
        check("sclk_rises", rise_cnt, NB);
        check("cmd_frame", {din_bits[0], din_bits[1], din_bits[2], din_bits[3]},
              {1'b1, 1'b1, exp_id, 1'b1});
        check("din_tail", 32'(din_bits[NB-1:4]), 32'd0);
      end
    end
    cs_prev   = adc_cs_n;
    sclk_prev = adc_sclk;
  end

  // ADC model for the small instance: fixed word, null bit forced high
  logic [DW6-1:0] word6 = 8'hA5;
  int             fall6 = 0;
  logic           cs6_prev = 1'b1;
  logic           sclk6_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (cs6_prev && !adc_cs_n6) begin
      fall6     = 0;
      adc_dout6 = 1'b0;
    end
    if (sclk6_prev && !adc_sclk6 && !adc_cs_n6) begin
      fall6++;
      if (fall6 == 4) adc_dout6 = 1'b1;
      else if (fall6 >= 5 && fall6 < 5 + int'(DW6)) adc_dout6 = word6[int'(DW6) - 1 - (fall6 - 5)];
      else adc_dout6 = 1'b0;
    end
    cs6_prev   = adc_cs_n6;
    sclk6_prev = adc_sclk6;
  end

  // Monitor: grants, cs_n timing, results and latency
  int   cyc = 0;
  int   gnt_cyc = -1000;
  int   gnt6_cyc = -1000;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    logic [DW:0]    e;
    logic [DW6-1:0] e6;
    cyc++;
    if (rstc_n) begin
      if (gnt != 2'b00) begin
        if (gnt_q.size() == 0) check("gnt_unexpected", 32'(gnt), 32'd0);
        else check("gnt_value", 32'(gnt), 32'(gnt_q.pop_front()));
        check("gnt_while_busy", 32'(prev_busy), 32'd0);
        check("cs_n_at_gnt", 32'(adc_cs_n), 32'd1);
        gnt_cyc = cyc;
      end
      if (cyc == gnt_cyc + 1) check("cs_n_low_t1", 32'(adc_cs_n), 32'd0);
      if (result_valid) begin
        if (res_q.size() == 0) begin
          check("result_unexpected", 32'd1, 32'd0);
        end else begin
          e = res_q.pop_front();
          check("result_id", 32'(result_id), 32'(e[DW]));
          check("result_data", 32'(result_data), 32'(e[DW-1:0]));
        end
        check("result_latency", cyc - gnt_cyc, 32'd125);
      end
      prev_busy = busy;

      if (gnt6 != 2'b00) gnt6_cyc = cyc;
      if (result_valid6) begin
        if (res6_q.size() == 0) begin
          check("result6_unexpected", 32'd1, 32'd0);
        end else begin
          e6 = res6_q.pop_front();
          check("result6_data", 32'(result_data6), 32'(e6));
          check("result6_id", 32'(result_id6), 32'd0);
        end
        check("result6_latency", cyc - gnt6_cyc, 32'd55);
      end
    end else begin
      prev_busy = 1'b0;
      gnt_cyc   = -1000;
      gnt6_cyc  = -1000;
    end
  end

  task automatic wait_gnt();
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_exp(input logic [1:0] g, input logic id, input logic [DW-1:0] d);
    gnt_q.push_back(g);
    res_q.push_back({id, d});
    frame_q.push_back(id);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstc_n = 1'b0;
    repeat (3) @(negedge clk);
    rstc_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_pins_reset(input string tag);
    check({tag, "_cs_n"}, 32'(adc_cs_n), 32'd1);
    check({tag, "_sclk"}, 32'(adc_sclk), 32'd0);
    check({tag, "_din"}, 32'(adc_din), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_rvalid"}, 32'(result_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    word[0] = '0;
    word[1] = '0;
    repeat (3) @(negedge clk);
    check_pins_reset("reset");
    check("reset_rdata", 32'(result_data), 32'd0);
    check("reset_rid", 32'(result_id), 32'd0);
    rstc_n = 1'b1;
    @(negedge clk);

    // single request on channel 0
    word[0] = 10'h025;
    null_bit = 1'b0;
    push_exp(2'b01, 1'b0, 10'h025);
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    wait_idle();

    // both requesting from reset: strict alternation
    do_reset();
    word[0] = 10'h155;
    word[1] = 10'h2AA;
    push_exp(2'b01, 1'b0, 10'h155);
    push_exp(2'b10, 1'b1, 10'h2AA);
    push_exp(2'b01, 1'b0, 10'h155);
    push_exp(2'b10, 1'b1, 10'h2AA);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt();
      if (k == 3) req = 2'b00;
    end
    wait_idle();

    // requester 1 arrives mid-conversion of requester 0
    word[0] = 10'h0F0;
    word[1] = 10'h30C;
    push_exp(2'b01, 1'b0, 10'h0F0);
    push_exp(2'b10, 1'b1, 10'h30C);
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    repeat (40) @(negedge clk);
    req = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("busy_fall_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("gnt_after_busy", 32'(gnt), 32'b10);
    req = 2'b00;
    wait_idle();

    // all-ones then all-zeros with the null bit driven high
    word[0] = 10'h3FF;
    null_bit = 1'b0;
    push_exp(2'b01, 1'b0, 10'h3FF);
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    wait_idle();
    word[0] = 10'h000;
    null_bit = 1'b1;
    push_exp(2'b01, 1'b0, 10'h000);
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    wait_idle();

    // reset at the eighth sclk rising edge aborts the conversion
    null_bit = 1'b0;
    word[0] = 10'h1C3;
    word[1] = 10'h07E;
    gnt_q.push_back(2'b01);
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #2;
      if (rise_cnt >= 8) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("sclk8_timeout", 32'd0, 32'd1);
    rstc_n = 1'b0;
    #1;
    check_pins_reset("abort");
    repeat (3) @(negedge clk);
    rstc_n = 1'b1;
    @(negedge clk);
    push_exp(2'b01, 1'b0, 10'h1C3);
    push_exp(2'b10, 1'b1, 10'h07E);
    req = 2'b11;
    wait_gnt();
    req = 2'b10;
    wait_gnt();
    req = 2'b00;
    wait_idle();

    // small instance: CLK_DIV=2, DATA_W=8
    res6_q.push_back(8'hA5);
    req6 = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt6 != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    check("gnt6_seen", 32'(seen), 32'd1);
    check("gnt6_value", 32'(gnt6), 32'b01);
    req6 = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy6) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("idle6_timeout", 32'd0, 32'd1);
    repeat (5) @(negedge clk);

    check("gnt_q_left", gnt_q.size(), 32'd0);
    check("res_q_left", res_q.size(), 32'd0);
    check("frame_q_left", frame_q.size(), 32'd0);
    check("res6_q_left", res6_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
